// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory: sequencer states,
// the response record and the per-byte write-enable merge.
package dmem_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    INIT,
    RUN
  } dmem_state_t;

  localparam int unsigned DMEM_DATA_W = 256;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } dmem_rsp_t;

  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] wdata_b,
                                          input logic       be);
    return be ? wdata_b : old_b;
  endfunction

endpackage

// File: rtl/dmem_rsp_skid.sv
// Two-entry valid/ready response FIFO. Entries are captured on the accept
// edge, so the head is visible in the cycle right after the request.
module dmem_rsp_skid
  import dmem_pkg::*;
#(
  parameter type T = dmem_rsp_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  T           i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output T           o_data,
  output logic [1:0] o_count
);

  T           r_entry [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_pop;

  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_entry[r_rd_ptr];
  assign o_count = r_count;

  // The producer never pushes while full, so push+pop only happens at count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (i_push) begin
        r_entry[r_wr_ptr] <= i_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/banked_data_memory_v2.sv
// PE data memory: byte-enable writes, registered reads through a 2-deep
// response FIFO, post-reset clear/init sequencer and out-of-range reporting.
module banked_data_memory_v2
  import dmem_pkg::*;
#(
  parameter int unsigned       DATA_W         = 256,
  parameter int unsigned       DEPTH          = 1024,
  parameter int unsigned       ADDR_W         = 32,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_WORD0     = {8{32'hBEEFCAFE}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NBYTES = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  dmem_state_t       r_state;
  logic [IDX_W-1:0]  r_clr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_merged;
  logic [1:0]        w_count;
  rsp_t              w_rsp;
  rsp_t              w_head;

  // High address bits only feed the range check; the array sees the low index.
  assign w_in_range = (req_addr < ADDR_W'(DEPTH));
  assign w_idx      = req_addr[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];

  assign busy      = (r_state != RUN);
  assign req_ready = (r_state == RUN) && (w_count < 2'd2);
  assign w_accept  = req_valid & req_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_merged = w_rd_word;
    for (int b = 0; b < NBYTES; b++) begin
      w_merged[8*b +: 8] = be_merge(w_rd_word[8*b +: 8], req_wdata[8*b +: 8], req_be[b]);
    end
    w_rsp.rdata = (!req_we && w_in_range) ? w_rd_word : '0;
    w_rsp.err   = ~w_in_range;
  end

  // Clear/init sequencer; after the last cleared word it seeds word 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state   <= CLEAR_ON_RESET ? CLEAR : INIT;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
            r_state <= INIT;
          end
        end
        INIT:    r_state <= RUN;
        default: r_state <= r_state;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (r_state == INIT) begin
        r_mem[0] <= INIT_WORD0;
      end else if (w_accept && req_we && w_in_range) begin
        r_mem[w_idx] <= w_merged;
      end
    end
  end

  dmem_rsp_skid #(
    .T(rsp_t)
  ) u_rsp_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (w_rsp),
    .o_valid (rsp_valid),
    .i_ready (rsp_ready),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign rsp_rdata = w_head.rdata;
  assign rsp_err   = w_head.err;

endmodule
